fmap_store: RTL
===============

# fmap_store

Feature-map store that sits immediately downstream of the activation stage. It captures each rectified value presented with the one-cycle write strobe into an internal buffer at sequentially incrementing addresses. Once a full map of FMAP_SIZE values is stored, it flags completion and lets the next layer stream the map back out in order. It is the receiving end of the activation write interface and the source for the following layer's input fetch.

## Interface
- DATA_W, 23: activation word width; matches the activation output.
- FMAP_SIZE, 3025: entries per map (55x55 conv1 output plane).
- ADDR_W, 12: address width; 2^ADDR_W must be at least FMAP_SIZE.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- write  in  1  write strobe from the activation stage; one value per high cycle.
- in  in  DATA_W  activation value; sampled when write=1.
- clear  in  1  synchronous abort: drop stored contents and return to FILL.
- rd_req  in  1  read request from the next layer; one entry per high cycle.
- rd_data  out  DATA_W  read data, registered.
- rd_valid  out  1  high the cycle rd_data holds a requested entry.
- frame_done  out  1  one-cycle pulse when the last entry of a map is written.
- ready  out  1  high in DRAIN, meaning a complete map is readable.
- ovf  out  1  sticky flag: a write arrived while in DRAIN.
- zero_cnt  out  ADDR_W  count of zero-valued writes in the current map.

## Operation
- FSM has two states.
  - FILL (reset state): accepts writes.
  - DRAIN: serves reads.
- FILL behaviour:
  - When write=1, store in at mem[wr_ptr] and increment wr_ptr.
  - When write=1 and wr_ptr==FMAP_SIZE-1: store the value, pulse frame_done, reset wr_ptr to 0, move to DRAIN.
  - rd_req is ignored in FILL. rd_valid stays 0.
- DRAIN behaviour:
  - ready=1.
  - When rd_req=1, read mem[rd_ptr] and increment rd_ptr.
  - When rd_req=1 and rd_ptr==FMAP_SIZE-1: reset rd_ptr to 0 and move to FILL. ready drops the next cycle.
  - A write in DRAIN is discarded, ovf is set, and no pointer moves.
- ovf clears only on rst or clear.
- clear has priority over write and rd_req in the same cycle. It zeroes wr_ptr, rd_ptr, zero_cnt and ovf, and sets the state to FILL. Memory contents are not cleared.
- No data transformation: values are stored and returned bit-exact. Pointers never exceed FMAP_SIZE-1; wrap is explicit, not modulo 2^ADDR_W.

## Timing
- Reset values: rd_data=0, rd_valid=0, frame_done=0, ready=0, ovf=0, zero_cnt=0, state=FILL, wr_ptr=0, rd_ptr=0.
- Write path: a value presented with write in cycle N is readable from cycle N+1 onward. frame_done is registered and is high in cycle N+1 for the last write.
- ready rises in the same cycle frame_done is high.
- Read latency: rd_req in cycle N gives rd_data and rd_valid in cycle N+1.
- Back-to-back rd_req gives one entry per cycle. rd_valid for the last entry still asserts after the state has returned to FILL.
- A write in the same cycle as the final rd_req is treated as a DRAIN write: it is discarded and sets ovf.
- rst asserted mid-map asynchronously returns all outputs to their reset values. Partial contents are abandoned.

## Configuration
- FMAP_STORE_ZCOUNT_EN defined:
  - zero_cnt increments on each accepted write whose value is 0, saturating at 2^ADDR_W-1.
  - It holds through DRAIN and resets to 0 on the first accepted write of the next map, or on clear/rst.
- FMAP_STORE_ZCOUNT_EN undefined: zero_cnt is tied to 0 and no counter logic is built.

## Structure
- Shared package holds:
  - the FSM state typedef (FILL, DRAIN);
  - the DATA_W and FMAP_SIZE defaults, so the activation stage and the next-layer fetch use the same values.
- One sub-module, fmap_store_ram: single-port-write / single-port-read synchronous RAM, DATA_W x 2^ADDR_W, registered read. The FSM, pointers and flags stay in the top module.

## Test plan
- Reset check: assert rst with no other activity. Every output reads 0 and ready=0.
- Fill and drain (FMAP_SIZE=16):
  - Write 0..15 on consecutive cycles. frame_done pulses once, one cycle after the 16th write, and ready=1.
  - Issue 16 back-to-back rd_req. rd_data returns 0..15 with one-cycle latency, then ready=0.
- Gapped traffic: write strobes with 1-3 idle cycles between them, and rd_req with random gaps. Ordering is preserved and rd_valid matches each rd_req delayed by one cycle.
- Overflow: fill a map, then write 0x7ABCD in DRAIN. ovf=1 and the drained data is unchanged. Then pulse clear. ovf=0, state=FILL, ready=0.
- Zero count with FMAP_STORE_ZCOUNT_EN: write 16 values of which 5 are 0. zero_cnt=5 at frame_done; without the macro, zero_cnt=0.
- Mid-operation reset: assert rst after 7 writes, then write a full map. frame_done fires after exactly 16 new writes.

Source files
------------

// File: rtl/fmap_store_pkg.sv
// Shared widths, map size and FSM state type for the feature-map store,
// the activation stage that writes it and the next-layer fetch that reads it.
package fmap_store_pkg;

  localparam int DATA_W_D    = 23;
  localparam int FMAP_SIZE_D = 3025;
  localparam int ADDR_W_D    = 12;

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } fmap_state_e;

endpackage

// File: rtl/fmap_store_ram.sv
// Feature-map buffer: one synchronous write port, one registered read port.
// Only the read register is reset; the array keeps whatever it last held.
module fmap_store_ram
  import fmap_store_pkg::*;
#(
  parameter int DATA_W = DATA_W_D,
  parameter int ADDR_W = ADDR_W_D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we)
      r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_rdata <= '0;
    else if (i_re)
      r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/fmap_store.sv
// Feature-map store: fills one map from the activation stage, then drains it.
// Define FMAP_STORE_ZCOUNT_EN to build the per-map zero-value counter.
module fmap_store
  import fmap_store_pkg::*;
#(
  parameter int DATA_W    = DATA_W_D,
  parameter int FMAP_SIZE = FMAP_SIZE_D,
  parameter int ADDR_W    = ADDR_W_D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_write,
  input  logic [DATA_W-1:0] i_in,
  input  logic              i_clear,
  input  logic              i_rd_req,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic              o_frame_done,
  output logic              o_ready,
  output logic              o_ovf,
  output logic [ADDR_W-1:0] o_zero_cnt
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FMAP_SIZE - 1);

  fmap_state_e       r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic              r_ovf;
  logic              r_frame_done;
  logic              r_rd_valid;

  logic w_wr_acc;
  logic w_rd_acc;
  logic w_last_wr;
  logic w_last_rd;

  // clear outranks both strobes
  assign w_wr_acc  = !i_clear && (r_state == FILL) && i_write;
  assign w_rd_acc  = !i_clear && (r_state == DRAIN) && i_rd_req;
  assign w_last_wr = w_wr_acc && (r_wr_ptr == LAST);
  assign w_last_rd = w_rd_acc && (r_rd_ptr == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= FILL;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_ovf        <= 1'b0;
      r_frame_done <= 1'b0;
      r_rd_valid   <= 1'b0;
    end else begin
      r_frame_done <= w_last_wr;
      r_rd_valid   <= w_rd_acc;
      if (i_clear) begin
        r_state  <= FILL;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_ovf    <= 1'b0;
      end else begin
        case (r_state)
          FILL: begin
            if (w_last_wr) begin
              r_wr_ptr <= '0;
              r_state  <= DRAIN;
            end else if (w_wr_acc) begin
              r_wr_ptr <= r_wr_ptr + 1'b1;
            end
          end
          DRAIN: begin
            if (i_write)
              r_ovf <= 1'b1;
            if (w_last_rd) begin
              r_rd_ptr <= '0;
              r_state  <= FILL;
            end else if (w_rd_acc) begin
              r_rd_ptr <= r_rd_ptr + 1'b1;
            end
          end
          default: r_state <= FILL;
        endcase
      end
    end
  end

  fmap_store_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (i_in),
    .i_re    (w_rd_acc),
    .i_raddr (r_rd_ptr),
    .o_rdata (o_rd_data)
  );

`ifdef FMAP_STORE_ZCOUNT_EN
  logic [ADDR_W-1:0] r_zero_cnt;
  logic              w_zero;

  assign w_zero = (i_in == '0);

  // the first write of a map restarts the count
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_zero_cnt <= '0;
    else if (i_clear)
      r_zero_cnt <= '0;
    else if (w_wr_acc) begin
      if (r_wr_ptr == '0)
        r_zero_cnt <= {{(ADDR_W-1){1'b0}}, w_zero};
      else if (w_zero && (r_zero_cnt != '1))
        r_zero_cnt <= r_zero_cnt + 1'b1;
    end
  end

  assign o_zero_cnt = r_zero_cnt;
`else
  assign o_zero_cnt = '0;
`endif

  assign o_rd_valid   = r_rd_valid;
  assign o_frame_done = r_frame_done;
  assign o_ready      = (r_state == DRAIN);
  assign o_ovf        = r_ovf;

endmodule
